// File: rtl/flag_issue_controller_pkg.sv
// Shared encodings for the CPSR flag issue controller: condition codes,
// flag bit positions inside {Z,C,N,V} and the stall FSM state encoding.
package flag_issue_controller_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // AL and NV do not look at the flags, so they never wait on a writer.
  function automatic logic cond_is_dependent(input logic [3:0] cond);
    return !((cond == COND_AL) || (cond == COND_NV));
  endfunction

endpackage

// File: rtl/flag_issue_controller_cond_check.sv
// ARM condition-code evaluator on a {Z,C,N,V} flag vector.
// NV evaluates as pass here; the caller masks it.
module flag_issue_controller_cond_check
  import flag_issue_controller_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_z;
  logic w_c;
  logic w_n;
  logic w_v;

  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_n = i_flags[FLAG_N];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b1;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      default: o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_issue_controller.sv
// Owns the CPSR flags, counts flag-writers in flight between issue and EX,
// forwards the last writer's flags and stalls ID on stale-flag reads.
module flag_issue_controller
  import flag_issue_controller_pkg::*;
#(
  parameter  int PEND_DEPTH = 3,
  localparam int PW         = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_cond,
  input  logic          id_s,
  output logic          id_ready,
  output logic          id_exec,
  input  logic          ex_flag_we,
  input  logic [3:0]    ex_flags,
  input  logic          flush,
  output logic [3:0]    sr,
  output logic [PW-1:0] pending,
  output logic [15:0]   stall_cycles,
  output logic          err,
  output logic [0:0]    dbg_state
);

  logic [3:0]    r_sr;
  logic [PW-1:0] r_pending;
  logic [15:0]   r_stall_cycles;
  logic          r_err;
  logic [0:0]    r_state;

  logic          w_dependent;
  logic          w_pend_zero;
  logic          w_pend_one;
  logic          w_pend_many;
  logic          w_pend_full;
  logic          w_forward;
  logic [3:0]    w_eff_flags;
  logic          w_dep_stall;
  logic          w_full_stall;
  logic          w_stall;
  logic          w_cond_pass;
  logic          w_issue;
  logic          w_inc;
  logic          w_dec;
  logic          w_count;
  logic [PW-1:0] w_pending_nxt;
  logic [0:0]    w_state_nxt;

  assign w_dependent = cond_is_dependent(id_cond);
  assign w_pend_zero = (r_pending == '0);
  assign w_pend_one  = (r_pending == PW'(1));
  assign w_pend_many = (r_pending > PW'(1));
  assign w_pend_full = (r_pending == PW'(PEND_DEPTH));

  // Only the single outstanding writer can be bypassed; with more in flight
  // the EX flags are already superseded by a younger writer.
  assign w_forward   = ex_flag_we & w_pend_one & ~flush;
  assign w_eff_flags = w_forward ? ex_flags : r_sr;

  assign w_dep_stall  = w_dependent & (w_pend_many | (w_pend_one & ~ex_flag_we));
  assign w_full_stall = id_s & w_pend_full & ~ex_flag_we;
  assign w_stall      = id_valid & (w_dep_stall | w_full_stall);

  flag_issue_controller_cond_check u_cond_check (
    .i_cond  (id_cond),
    .i_flags (w_eff_flags),
    .o_pass  (w_cond_pass)
  );

  assign id_ready = ~w_stall & ~flush;
  assign id_exec  = w_cond_pass & (id_cond != COND_NV);

  assign w_issue = id_valid & id_ready;
  assign w_inc   = w_issue & id_s & id_exec;
  assign w_dec   = ex_flag_we & ~w_pend_zero;

  always_comb begin
    w_pending_nxt = r_pending;
    if (flush) begin
      w_pending_nxt = '0;
    end else if (w_inc & ~w_dec) begin
      w_pending_nxt = r_pending + PW'(1);
    end else if (w_dec & ~w_inc) begin
      w_pending_nxt = r_pending - PW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_stall) w_state_nxt = ST_STALL;
      ST_STALL: if (~w_stall | flush) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // The exit cycle of a stall (dependency resolved, id_valid dropped or
  // flush) is not a lost cycle and is not counted.
  assign w_count = (r_state == ST_STALL) & w_stall & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr           <= '0;
      r_pending      <= '0;
      r_stall_cycles <= '0;
      r_err          <= 1'b0;
      r_state        <= ST_RUN;
    end else begin
      r_pending <= w_pending_nxt;
      r_state   <= w_state_nxt;
      if (ex_flag_we) begin
        r_sr <= ex_flags;
      end
      if (ex_flag_we & w_pend_zero) begin
        r_err <= 1'b1;
      end
      if (w_count && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign sr           = r_sr;
  assign pending      = r_pending;
  assign stall_cycles = r_stall_cycles;
  assign err          = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_flag_issue_controller.sv
// Directed bench for flag_issue_controller: per-cycle vector table plus
// hand-written saturation and mid-stall reset sequences.
module tb_flag_issue_controller;
  import flag_issue_controller_pkg::*;

  localparam int PEND_DEPTH = 3;
  localparam int PW         = $clog2(PEND_DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [3:0]    id_cond;
  logic          id_s;
  logic          id_ready;
  logic          id_exec;
  logic          ex_flag_we;
  logic [3:0]    ex_flags;
  logic          flush;
  logic [3:0]    sr;
  logic [PW-1:0] pending;
  logic [15:0]   stall_cycles;
  logic          err;
  logic [0:0]    dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  flag_issue_controller #(.PEND_DEPTH(PEND_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_cond      (id_cond),
    .id_s         (id_s),
    .id_ready     (id_ready),
    .id_exec      (id_exec),
    .ex_flag_we   (ex_flag_we),
    .ex_flags     (ex_flags),
    .flush        (flush),
    .sr           (sr),
    .pending      (pending),
    .stall_cycles (stall_cycles),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  cond;
    logic        s;
    logic        we;
    logic [3:0]  fl;
    logic        fx;
    logic        rdy;
    logic        ex;
    logic [3:0]  sr;
    logic [1:0]  pend;
    logic        err;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] cond, input logic s,
                     input logic we, input logic [3:0] fl, input logic fx,
                     input logic rdy, input logic ex, input logic [3:0] e_sr,
                     input logic [1:0] e_pend, input logic e_err,
                     input logic [15:0] e_sc);
    vec_t r;
    r.v = v; r.cond = cond; r.s = s; r.we = we; r.fl = fl; r.fx = fx;
    r.rdy = rdy; r.ex = ex; r.sr = e_sr; r.pend = e_pend; r.err = e_err;
    r.sc = e_sc;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] cond, input logic s,
                       input logic we, input logic [3:0] fl, input logic fx);
    id_valid = v; id_cond = cond; id_s = s;
    ex_flag_we = we; ex_flags = fl; flush = fx;
  endtask

  initial begin
    drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.sr", 32'(sr), 32'h0);
    check("rst.pending", 32'(pending), 32'h0);
    check("rst.err", 32'(err), 32'h0);
    check("rst.stall_cycles", 32'(stall_cycles), 32'h0);
    check("rst.state", 32'(dbg_state), 32'(ST_RUN));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //   v  cond     s  we fl     fx | rdy ex sr     p  err sc
    add(1, COND_EQ,  0, 0, 4'h0, 0,   1,  0, 4'h0,  0, 0,  0);
    add(1, COND_NE,  0, 0, 4'h0, 0,   1,  1, 4'h0,  0, 0,  0);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h0,  1, 0,  0);
    add(1, COND_EQ,  0, 1, 4'h8, 0,   1,  1, 4'h8,  0, 0,  0);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h8,  1, 0,  0);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h8,  2, 0,  0);
    add(1, COND_GT,  0, 0, 4'h0, 0,   0,  0, 4'h8,  2, 0,  0);
    add(1, COND_GT,  0, 1, 4'h0, 0,   0,  0, 4'h0,  1, 0,  1);
    add(1, COND_GT,  0, 1, 4'h3, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_MI,  0, 0, 4'h0, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_VS,  0, 0, 4'h0, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_HI,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_LS,  0, 0, 4'h0, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_GE,  0, 0, 4'h0, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_LT,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_LE,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_NV,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_CS,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_CC,  0, 0, 4'h0, 0,   1,  1, 4'h3,  0, 0,  1);
    add(1, COND_PL,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_VC,  0, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_NV,  1, 0, 4'h0, 0,   1,  0, 4'h3,  0, 0,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h3,  1, 0,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h3,  2, 0,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'h3,  3, 0,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   0,  1, 4'h3,  3, 0,  1);
    add(1, COND_AL,  1, 1, 4'h4, 0,   1,  1, 4'h4,  3, 0,  1);
    add(0, COND_EQ,  0, 1, 4'hC, 0,   1,  0, 4'hC,  2, 0,  1);
    add(1, COND_EQ,  0, 1, 4'h6, 1,   0,  1, 4'h6,  0, 0,  1);
    add(0, COND_EQ,  0, 1, 4'hF, 0,   1,  0, 4'hF,  0, 1,  1);
    add(1, COND_EQ,  0, 0, 4'h0, 0,   1,  1, 4'hF,  0, 1,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'hF,  1, 1,  1);
    add(1, COND_AL,  1, 0, 4'h0, 0,   1,  1, 4'hF,  2, 1,  1);
    add(1, COND_EQ,  0, 0, 4'h0, 0,   0,  1, 4'hF,  2, 1,  1);
    add(1, COND_EQ,  0, 0, 4'h0, 0,   0,  1, 4'hF,  2, 1,  2);
    add(0, COND_EQ,  0, 0, 4'h0, 0,   1,  1, 4'hF,  2, 1,  2);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].cond, vecs[i].s, vecs[i].we, vecs[i].fl, vecs[i].fx);
      @(negedge clk);
      check($sformatf("row%0d.id_ready", i), 32'(id_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d.id_exec", i), 32'(id_exec), 32'(vecs[i].ex));
      @(posedge clk);
      #1;
      check($sformatf("row%0d.sr", i), 32'(sr), 32'(vecs[i].sr));
      check($sformatf("row%0d.pending", i), 32'(pending), 32'(vecs[i].pend));
      check($sformatf("row%0d.err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("row%0d.stall_cycles", i), 32'(stall_cycles), 32'(vecs[i].sc));
    end

    // Saturation: two writers still outstanding, GT held with no flag write.
    drive(1'b1, COND_GT, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    check("sat.stall_cycles", 32'(stall_cycles), 32'hFFFF);
    check("sat.pending", 32'(pending), 32'h2);
    check("sat.state", 32'(dbg_state), 32'(ST_STALL));
    check("sat.id_ready", 32'(id_ready), 32'h0);

    // Asynchronous reset in the middle of the stall, away from any edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst.sr", 32'(sr), 32'h0);
    check("arst.pending", 32'(pending), 32'h0);
    check("arst.err", 32'(err), 32'h0);
    check("arst.stall_cycles", 32'(stall_cycles), 32'h0);
    check("arst.state", 32'(dbg_state), 32'(ST_RUN));
    check("arst.id_ready", 32'(id_ready), 32'h1);
    check("arst.id_exec", 32'(id_exec), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.id_ready", 32'(id_ready), 32'h1);
    check("post_rst.pending", 32'(pending), 32'h0);
    check("post_rst.state", 32'(dbg_state), 32'(ST_RUN));

    drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
